// File: rtl/recurrence_engine.sv
// recurrence_engine: four-step register recurrence (a=b+c, d=a-3, b=d+10, c=c+1) repeated ITER times,
// reporting each step as a ready/valid record; all outputs come straight from flops.
module recurrence_engine #(
  parameter int WIDTH = 32,
  parameter int ITER  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] init_a,
  input  logic signed [WIDTH-1:0] init_b,
  input  logic signed [WIDTH-1:0] init_c,
  input  logic signed [WIDTH-1:0] init_d,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_a,
  output logic signed [WIDTH-1:0] out_b,
  output logic signed [WIDTH-1:0] out_c,
  output logic signed [WIDTH-1:0] out_d,
  output logic [1:0]              out_step,
  output logic [7:0]              out_iter
);
  typedef enum logic [1:0] {IDLE, EXEC, EMIT, DONE} state_e;
  localparam logic signed [WIDTH-1:0] K1  = WIDTH'(1);
  localparam logic signed [WIDTH-1:0] K3  = WIDTH'(3);
  localparam logic signed [WIDTH-1:0] K10 = WIDTH'(10);
  localparam logic [7:0] LAST_ITER = 8'(ITER - 1);
  state_e state_q, state_d;
  logic signed [WIDTH-1:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic signed [WIDTH-1:0] oa_q, ob_q, oc_q, od_q;
  logic [1:0] step_q, step_d;
  logic [7:0] iter_q, iter_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic load, exec, hs, last;
  always_comb begin
    load = state_q == IDLE && start;
    exec = state_q == EXEC;
    hs   = state_q == EMIT && out_ready;
    last = step_q == 2'd3 && iter_q == LAST_ITER;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? EXEC : IDLE) :
              (state_q == EXEC) ? EMIT :
              (state_q == EMIT) ? (hs ? (last ? DONE : EXEC) : EMIT) :
              IDLE;
  end
  // Each step writes one register from values committed by the previous step.
  always_comb begin
    a_d    = load ? init_a : (exec && step_q == 2'd0) ? b_q + c_q : a_q;
    d_d    = load ? init_d : (exec && step_q == 2'd1) ? a_q - K3  : d_q;
    b_d    = load ? init_b : (exec && step_q == 2'd2) ? d_q + K10 : b_q;
    c_d    = load ? init_c : (exec && step_q == 2'd3) ? c_q + K1  : c_q;
    step_d = load ? 2'd0 : (hs && !last) ? step_q + 2'd1 : step_q;
    iter_d = load ? 8'd0 : (hs && step_q == 2'd3 && !last) ? iter_q + 8'd1 : iter_q;
  end
  always_comb begin
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    valid_d = state_d == EMIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      oc_q    <= '0;
      od_q    <= '0;
      step_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      oa_q    <= exec ? a_d : oa_q;
      ob_q    <= exec ? b_d : ob_q;
      oc_q    <= exec ? c_d : oc_q;
      od_q    <= exec ? d_d : od_q;
      step_q  <= step_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_a     = oa_q;
  assign out_b     = ob_q;
  assign out_c     = oc_q;
  assign out_d     = od_q;
  assign out_step  = step_q;
  assign out_iter  = iter_q;
endmodule

// File: doc/recurrence_engine.md
RECURRENCE_ENGINE -- requirements
Module: recurrence_engine

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the signed width of every data register and data port.
REQ-002 Parameter ITER, default 4, range 1..255, SHALL set the number of 4-step iterations per run.
REQ-003 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  run request, sampled only in IDLE.
REQ-007 init_a, init_b, init_c, init_d  in  WIDTH each  signed initial values, captured on start acceptance.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse on run completion.
REQ-010 out_valid  out  1  step record valid.
REQ-011 out_ready  in  1  downstream accepts record.
REQ-012 out_a, out_b, out_c, out_d  out  WIDTH each  register values after the reported step.
REQ-013 out_step  out  2  step index 0..3 of the reported record.
REQ-014 out_iter  out  8  iteration index 0..ITER-1 of the reported record.

Function
REQ-015 States SHALL be IDLE, EXEC, EMIT, DONE.
REQ-016 IDLE: start=1 SHALL load a..d from init_*, clear step and iter counters, and go to EXEC next cycle; start=0 stays in IDLE.
REQ-017 EXEC (exactly one cycle) SHALL apply one update selected by step: 0 a=b+c; 1 d=a-3; 2 b=d+10; 3 c=c+1; then go to EMIT.
REQ-018 Each update SHALL read values committed by all earlier steps, so step k+1 sees the result of step k.
REQ-019 EMIT SHALL hold out_valid=1 with out_a..d, out_step, out_iter stable until out_valid and out_ready are both high on a clock edge.
REQ-020 On that handshake edge with step<3, step SHALL increment and the state SHALL go to EXEC.
REQ-021 On that handshake edge with step=3 and iter<ITER-1, step SHALL wrap to 0, iter SHALL increment, and the state SHALL go to EXEC.
REQ-022 On that handshake edge with step=3 and iter=ITER-1, the state SHALL go to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; out_a..d SHALL retain the final values.
REQ-024 Latency: the first out_valid SHALL rise 2 cycles after the start-acceptance edge.
REQ-025 Throughput: at most one record per 2 cycles; a run SHALL emit exactly 4*ITER records.
REQ-026 Arithmetic SHALL be two's-complement modulo 2^WIDTH, with silent wrap and no saturation or flag.
REQ-027 out_valid SHALL be low in IDLE, EXEC and DONE.
REQ-028 start asserted outside IDLE SHALL be ignored, with no reload and no queuing.
REQ-029 out_ready high while out_valid is low SHALL have no effect.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from out_ready to any output.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, out_valid=0, out_a..d=0, out_step=0, out_iter=0, and internal a..d and counters to 0.
REQ-032 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-033 After reset release, the block SHALL accept start on the first rising edge.

Verification
REQ-034 Nominal run, WIDTH=32, ITER=4, init 30/20/15/5, out_ready=1 -> records (a,b,c,d) = (35,20,15,5), (35,20,15,32), (35,42,15,32), (35,42,16,32), ...; 16 records total; last record (107,114,19,104) with step=3, iter=3; then a single done pulse.
REQ-035 Backpressure: same run with out_ready low for 5 cycles during EMIT of record 2 -> out_valid stays high, outputs remain (35,20,15,32), and the record is accepted exactly once.
REQ-036 Overflow wrap, WIDTH=8, init a=0, b=127, c=1, d=0 -> first record a=-128.
REQ-037 start held high during a run -> no reload, still exactly 16 records, and done fires once.
REQ-038 rst_n pulsed low during record 7 -> all outputs 0 and no done; a new start then yields 16 records from the new init values.
